// File: rtl/approx_mult_err_sweeper_if.sv
// approx_mult_err_sweeper_if
// Bundles the control, multiplier and register-read signals of the
// approximate-multiplier error sweeper.
//
// Handshake: start is a level request that is only looked at while the
// sweeper is idle or finished. busy rises on the edge that accepts start and
// stays high until the last pair has been accumulated. done pulses for
// exactly one cycle on the edge where busy falls. A start seen while busy is
// dropped; there is no queueing. mult_a/mult_b are registered operands and
// mult_p must be a purely combinational function of them. rd_addr is sampled
// every edge, and rd_data shows the selected register one cycle later.
interface approx_mult_err_sweeper_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     mult_a;
    logic [WIDTH-1:0]     mult_b;
    logic [2*WIDTH-2:0]   mult_p;
    logic [4:0]           rd_addr;
    logic [CNT_W-1:0]     rd_data;
    logic [1:0]           state_dbg;

    // Sweeper side: drives operands, status and read data.
    modport master (
        input  start,
        input  mult_p,
        input  rd_addr,
        output busy,
        output done,
        output mult_a,
        output mult_b,
        output rd_data,
        output state_dbg
    );

    // Environment side: multiplier under test plus the register reader.
    modport slave (
        output start,
        output mult_p,
        output rd_addr,
        input  busy,
        input  done,
        input  mult_a,
        input  mult_b,
        input  rd_data,
        input  state_dbg
    );
endinterface

// File: rtl/approx_mult_err_sweeper.sv
// approx_mult_err_sweeper
// Sweeps every operand pair 1 <= b <= a <= 2^WIDTH-1 through an external
// combinational approximate multiplier at one pair per clock. For each product
// bit it counts how often the approximate product differs from the exact one.
// Optional macro ABS_ERR_ACC_EN adds a maximum absolute error register that is
// readable at rd_addr 25. WIDTH must stay <= 12 so that the bit counters
// (addresses 0..2*WIDTH-1) do not overlap addresses 24/25.
module approx_mult_err_sweeper #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    approx_mult_err_sweeper_if.master bus
);
    localparam int               PW        = 2 * WIDTH;
    localparam logic [WIDTH-1:0] OP_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [4:0]       ADDR_PAIR = 5'd24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             start_sweep;
    logic             issue;
    logic             accum;
    logic             first;       // next issue is the first pair (1,1)
    logic             issued_all;  // last pair has been put on the operands
    logic             cmp_vld;     // operands hold a pair not yet accumulated
    logic             done_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic [PW-1:0]    exact;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    diff;
    logic [CNT_W-1:0] err_cnt [PW];
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] rd_q;
    logic [CNT_W-1:0] rd_nxt;

    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.mult_a    = a_q;
    assign bus.mult_b    = b_q;
    assign bus.rd_data   = rd_q;
    assign bus.state_dbg = state;

    assign issue = (state == RUN) && !issued_all;
    assign accum = (state == RUN) && cmp_vld;

    // The multiplier output is one bit short of the exact product, so its MSB is 0.
    assign exact = PW'(a_q) * PW'(b_q);
    assign prod  = {1'b0, bus.mult_p};
    assign diff  = exact ^ prod;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: start is honoured only from IDLE/DONE; RUN ends on the last accumulate.
    always_comb begin
        state_nxt   = state;
        start_sweep = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = RUN;
                    start_sweep = 1'b1;
                end
            end
            RUN: begin
                if (issued_all && cmp_vld) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next operand pair in (a ascending, b = 1..a) order.
    always_comb begin
        nxt_a = a_q;
        nxt_b = b_q;
        if (first) begin
            nxt_a = WIDTH'(1);
            nxt_b = WIDTH'(1);
        end else if (b_q < a_q) begin
            nxt_b = b_q + WIDTH'(1);
        end else begin
            nxt_a = a_q + WIDTH'(1);
            nxt_b = WIDTH'(1);
        end
    end

    // Operand issue: the start cycle primes; the pairs follow, one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            first      <= 1'b0;
            issued_all <= 1'b0;
            cmp_vld    <= 1'b0;
        end else if (start_sweep) begin
            first      <= 1'b1;
            issued_all <= 1'b0;
            cmp_vld    <= 1'b0;
        end else if (issue) begin
            a_q        <= nxt_a;
            b_q        <= nxt_b;
            first      <= 1'b0;
            cmp_vld    <= 1'b1;
            issued_all <= (nxt_a == OP_MAX) && (nxt_b == OP_MAX);
        end else begin
            cmp_vld    <= 1'b0;
        end
    end

    // Done pulse on the edge that performs the final accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state == RUN) && (state_nxt == DONE);
    end

    // Saturating per-bit mismatch counters and pair counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PW; i++) err_cnt[i] <= '0;
            pair_cnt <= '0;
        end else if (start_sweep) begin
            for (int i = 0; i < PW; i++) err_cnt[i] <= '0;
            pair_cnt <= '0;
        end else if (accum) begin
            for (int i = 0; i < PW; i++) begin
                if (diff[i] && (err_cnt[i] != CNT_MAX)) err_cnt[i] <= err_cnt[i] + CNT_W'(1);
            end
            if (pair_cnt != CNT_MAX) pair_cnt <= pair_cnt + CNT_W'(1);
        end
    end

`ifdef ABS_ERR_ACC_EN
    localparam logic [4:0] ADDR_MAXERR = 5'd25;

    logic [PW-1:0]    max_err;
    logic [PW-1:0]    abs_err;
    logic [CNT_W-1:0] max_err_rd;

    assign abs_err = (exact >= prod) ? (exact - prod) : (prod - exact);

    // The register is PW bits wide; the read port zero-extends or truncates it.
    if (CNT_W >= PW) begin : g_max_ext
        assign max_err_rd = CNT_W'(max_err);
    end else begin : g_max_trunc
        assign max_err_rd = max_err[CNT_W-1:0];
    end

    // Running maximum of |exact - prod| over the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          max_err <= '0;
        else if (start_sweep)                max_err <= '0;
        else if (accum && abs_err > max_err) max_err <= abs_err;
    end
`endif

    // Read mux; unmapped addresses return 0.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < PW; i++) begin
            if (bus.rd_addr == 5'(i)) rd_nxt = err_cnt[i];
        end
        if (bus.rd_addr == ADDR_PAIR) rd_nxt = pair_cnt;
`ifdef ABS_ERR_ACC_EN
        if (bus.rd_addr == ADDR_MAXERR) rd_nxt = max_err_rd;
`endif
    end

    // Registered read data: one cycle of read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_nxt;
    end
endmodule

// File: tb/tb_approx_mult_err_sweeper.sv
// tb_approx_mult_err_sweeper
// Three sweepers share one clock/reset: WIDTH=2/CNT_W=16 with a selectable
// multiplier model, WIDTH=2/CNT_W=2 with mult_p tied to 0 (saturation), and
// WIDTH=8/CNT_W=16 with an exact-truncated multiplier. Expected counts come
// from a plain loop over all operand pairs.
module tb_approx_mult_err_sweeper;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    approx_mult_err_sweeper_if #(.WIDTH(2), .CNT_W(16)) if_w2 ();
    approx_mult_err_sweeper_if #(.WIDTH(2), .CNT_W(2))  if_w2s ();
    approx_mult_err_sweeper_if #(.WIDTH(8), .CNT_W(16)) if_w8 ();

    approx_mult_err_sweeper #(.WIDTH(2), .CNT_W(16)) u_w2  (.clk(clk), .rst_n(rst_n), .bus(if_w2));
    approx_mult_err_sweeper #(.WIDTH(2), .CNT_W(2))  u_w2s (.clk(clk), .rst_n(rst_n), .bus(if_w2s));
    approx_mult_err_sweeper #(.WIDTH(8), .CNT_W(16)) u_w8  (.clk(clk), .rst_n(rst_n), .bus(if_w8));

    int         n_tests;
    int         n_fail;
    int         mode_w2;        // 0 exact truncated, 1 zero, 2 random table
    logic [2:0] lut2 [16];
    logic [1:0] idle_code;
    int         exp_err [16];
    int         exp_pair;
    longint     exp_max;

    // Multiplier models driven back into the DUTs.
    always_comb begin
        case (mode_w2)
            0:       if_w2.mult_p = 3'(int'(if_w2.mult_a) * int'(if_w2.mult_b));
            1:       if_w2.mult_p = 3'd0;
            default: if_w2.mult_p = lut2[{if_w2.mult_a, if_w2.mult_b}];
        endcase
    end
    assign if_w2s.mult_p = '0;
    always_comb if_w8.mult_p = 15'(int'(if_w8.mult_a) * int'(if_w8.mult_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_p(input int w, input int mode, input int a, input int b);
        if (w != 2 || mode == 0) return a * b;
        if (mode == 1) return 0;
        return int'(lut2[a * 4 + b]);
    endfunction

    // Reference: walk all pairs, count differing bits, then saturate/truncate.
    task automatic model(input int w, input int cnt_w, input int mode);
        int raw [16];
        int pmask, sat, ex, pr, d, pairs, ae, mx;
        pmask = (1 << (2 * w - 1)) - 1;
        sat   = (1 << cnt_w) - 1;
        pairs = 0;
        mx    = 0;
        for (int i = 0; i < 16; i++) raw[i] = 0;
        for (int a = 1; a < (1 << w); a++) begin
            for (int b = 1; b <= a; b++) begin
                ex = a * b;
                pr = model_p(w, mode, a, b) & pmask;
                d  = ex ^ pr;
                for (int i = 0; i < 2 * w; i++) if (((d >> i) & 1) == 1) raw[i]++;
                pairs++;
                ae = (ex > pr) ? ex - pr : pr - ex;
                if (ae > mx) mx = ae;
            end
        end
        for (int i = 0; i < 16; i++) exp_err[i] = (raw[i] < sat) ? raw[i] : sat;
        exp_pair = (pairs < sat) ? pairs : sat;
        exp_max  = longint'(mx & sat);
    endtask

    function automatic longint exp_at(input int w, input int addr);
        if (addr < 2 * w) return longint'(exp_err[addr]);
        if (addr == 24) return longint'(exp_pair);
`ifdef ABS_ERR_ACC_EN
        if (addr == 25) return exp_max;
`endif
        return 0;
    endfunction

    task automatic rd(input logic [4:0] addr);
        if_w2.rd_addr  = addr;
        if_w2s.rd_addr = addr;
        if_w8.rd_addr  = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic set_start_w2(input logic v);
        if_w2.start  = v;
        if_w2s.start = v;
    endtask

    // One WIDTH=2 sweep (both WIDTH=2 instances) with optional twists.
    task automatic run_w2(input int mode, input bit mid_pulse, input bit hold, input bit chk_clear);
        logic [3:0] obs_q[$];
        logic [3:0] exp_q[$];
        logic [4:0] addrs [8];
        longint     g2  [8];
        longint     g2s [8];
        int         cyc, k;
        addrs   = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd24, 5'd25, 5'd20, 5'd31};
        mode_w2 = mode;
        if_w2.rd_addr = 5'd24;
        set_start_w2(1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_start_w2(1'b0);
        check("w2_busy_rise", if_w2.busy, 1);
        check("w2_state_run", (if_w2.state_dbg != idle_code), 1);
        if (chk_clear) check("w2_rd_pre_clear", if_w2.rd_data, 6);
        cyc = 1;
        k   = 0;
        while (k < 50) begin
            @(posedge clk);
            #1;
            k++;
            if (chk_clear && k == 1) check("w2_rd_cleared", if_w2.rd_data, 0);
            if (mid_pulse && k == 3) set_start_w2(1'b1);
            if (mid_pulse && k == 4) set_start_w2(1'b0);
            if (!if_w2.busy) break;
            cyc++;
            obs_q.push_back({if_w2.mult_a, if_w2.mult_b});
        end
        if (!hold) set_start_w2(1'b0);
        check("w2_done_pulse", if_w2.done, 1);
        check("w2_busy_cycles", cyc, 7);
        for (int a = 1; a < 4; a++)
            for (int b = 1; b <= a; b++) exp_q.push_back({2'(a), 2'(b)});
        check("w2_pair_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("w2_pair%0d", i + 1), obs_q[i], exp_q[i]);
        if (hold) begin
            @(posedge clk);
            #1;
            check("w2_hold_restart", if_w2.busy, 1);
            set_start_w2(1'b0);
            cyc = 1;
            k   = 0;
            while (k < 50) begin
                @(posedge clk);
                #1;
                k++;
                if (!if_w2.busy) break;
                cyc++;
            end
            check("w2_hold_busy_cycles", cyc, 7);
            check("w2_hold_done", if_w2.done, 1);
        end
        @(posedge clk);
        #1;
        check("w2_done_drop", if_w2.done, 0);
        for (int j = 0; j < 8; j++) begin
            rd(addrs[j]);
            g2[j]  = longint'(if_w2.rd_data);
            g2s[j] = longint'(if_w2s.rd_data);
        end
        model(2, 16, mode);
        for (int j = 0; j < 8; j++)
            check($sformatf("w2_m%0d_rd%0d", mode, addrs[j]), g2[j], exp_at(2, int'(addrs[j])));
        model(2, 2, 1);
        for (int j = 0; j < 8; j++)
            check($sformatf("w2s_rd%0d", addrs[j]), g2s[j], exp_at(2, int'(addrs[j])));
    endtask

    initial begin
        int     cyc, k, pa, pb, done_busy;
        longint g8 [20];
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        mode_w2 = 0;
        set_start_w2(1'b0);
        if_w8.start    = 1'b0;
        if_w2.rd_addr  = '0;
        if_w2s.rd_addr = '0;
        if_w8.rd_addr  = '0;
        for (int i = 0; i < 16; i++) lut2[i] = 3'($urandom_range(0, 7));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_w8_busy", if_w8.busy, 0);
        check("rst_w8_done", if_w8.done, 0);
        check("rst_w8_a", if_w8.mult_a, 0);
        check("rst_w8_b", if_w8.mult_b, 0);
        check("rst_w8_rd", if_w8.rd_data, 0);
        check("rst_w2_busy", if_w2.busy, 0);
        check("rst_w2_done", if_w2.done, 0);
        check("rst_w2_a", if_w2.mult_a, 0);
        check("rst_w2_b", if_w2.mult_b, 0);
        check("rst_w2_rd", if_w2.rd_data, 0);
        idle_code = if_w2.state_dbg;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // WIDTH=2 sweeps.
        run_w2(0, 1'b0, 1'b0, 1'b0);
        run_w2(1, 1'b0, 1'b0, 1'b0);
        run_w2(2, 1'b1, 1'b0, 1'b0);
        run_w2(2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) lut2[i] = 3'($urandom_range(0, 7));
        run_w2(2, 1'b0, 1'b1, 1'b0);
        run_w2(1, 1'b0, 1'b0, 1'b1);

        // WIDTH=8: asynchronous reset while pair 100 is on the operands.
        k = 0;
        pa = 0;
        pb = 0;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b <= a; b++) begin
                k++;
                if (k == 100) begin pa = a; pb = b; end
            end
        if_w8.start = 1'b1;
        @(posedge clk);
        #1;
        if_w8.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("w8_pair100_a", if_w8.mult_a, pa);
        check("w8_pair100_b", if_w8.mult_b, pb);
        #2;
        rst_n = 1'b0;
        #1;
        check("w8_arst_busy", if_w8.busy, 0);
        check("w8_arst_a", if_w8.mult_a, 0);
        check("w8_arst_b", if_w8.mult_b, 0);
        check("w8_arst_rd", if_w8.rd_data, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("w8_arst_no_done", if_w8.done, 0);
        end
        rst_n = 1'b1;
        rd(5'd24);
        check("w8_arst_pair_cnt", if_w8.rd_data, 0);
        check("w8_arst_stays_idle", if_w8.busy, 0);
        check("w8_arst_no_done2", if_w8.done, 0);
        rd(5'd15);
        check("w8_arst_err15", if_w8.rd_data, 0);

        // WIDTH=8: full uninterrupted sweep with an exact-truncated multiplier.
        if_w8.start = 1'b1;
        @(posedge clk);
        #1;
        if_w8.start = 1'b0;
        check("w8_busy_rise", if_w8.busy, 1);
        cyc = 1;
        k = 0;
        done_busy = 0;
        while (k < 40000) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                check("w8_pair1_a", if_w8.mult_a, 1);
                check("w8_pair1_b", if_w8.mult_b, 1);
            end
            if (!if_w8.busy) break;
            if (if_w8.done) done_busy++;
            cyc++;
        end
        check("w8_busy_cycles", cyc, 32641);
        check("w8_done_pulse", if_w8.done, 1);
        check("w8_no_early_done", done_busy, 0);
        check("w8_last_a", if_w8.mult_a, 255);
        check("w8_last_b", if_w8.mult_b, 255);
        @(posedge clk);
        #1;
        check("w8_done_drop", if_w8.done, 0);
        check("w8_hold_a", if_w8.mult_a, 255);
        check("w8_hold_b", if_w8.mult_b, 255);
        for (int j = 0; j < 16; j++) begin
            rd(5'(j));
            g8[j] = longint'(if_w8.rd_data);
        end
        rd(5'd24);
        g8[16] = longint'(if_w8.rd_data);
        rd(5'd25);
        g8[17] = longint'(if_w8.rd_data);
        rd(5'd20);
        g8[18] = longint'(if_w8.rd_data);
        rd(5'd31);
        g8[19] = longint'(if_w8.rd_data);
        model(8, 16, 0);
        for (int j = 0; j < 16; j++) check($sformatf("w8_err%0d", j), g8[j], exp_at(8, j));
        check("w8_pair_cnt", g8[16], 32640);
        check("w8_rd25", g8[17], exp_at(8, 25));
        check("w8_rd20", g8[18], 0);
        check("w8_rd31", g8[19], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
